line_memory_responder: RTL and testbench

//  Main-memory responder at the far end of the data-cache refill/write-back interface.

---
 rtl/line_memory_responder.sv | 121 ++++++++++++
 tb/tb_line_memory_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// Main-memory line responder for the dcache refill/write-back port: accepts one
// 256-bit line request, waits a fixed latency, then writes or returns the line.
module line_memory_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_ack_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = 27;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_wr;
  logic [IDX_W-1:0]    r_idx;
  logic [LINE_W-1:0]   r_data;
  logic [LINE_W-1:0]   r_rdata;
  logic                r_ack, r_busy, r_err;
  logic [LINE_W-1:0]   r_mem [DEPTH];

  logic                w_accept, w_complete, w_wr, w_err, w_unused;
  logic [IDX_W-1:0]    w_idx;
  logic [LINE_W-1:0]   w_data;
  logic [AW-1:0]       w_row;

  assign w_unused = ^mem_addr_i[4:0];

  // With LATENCY=1 the accepting edge is also the completion edge, so the
  // request fields come straight from the ports instead of the latched copy.
  assign w_wr   = (r_state == IDLE) ? mem_write_i      : r_wr;
  assign w_idx  = (r_state == IDLE) ? mem_addr_i[31:5] : r_idx;
  assign w_data = (r_state == IDLE) ? mem_data_i       : r_data;
  assign w_err  = (w_idx >= IDX_W'(DEPTH));
  assign w_row  = w_idx[AW-1:0];

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_enable_i) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_complete = 1'b1;
            w_next     = ACK;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!mem_enable_i) begin
          w_next = IDLE;
        end else if (r_cnt == '0) begin
          w_complete = 1'b1;
          w_next     = ACK;
        end
      end
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wr   <= mem_write_i;
        r_idx  <= mem_addr_i[31:5];
        r_data <= mem_data_i;
        r_cnt  <= CNT_W'(LATENCY - 1);
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_ack  <= w_complete;
      r_err  <= w_complete && w_err;
      r_busy <= (w_next != IDLE);
      if (w_complete && !w_wr) begin
        r_rdata <= w_err ? '0 : r_mem[w_row];
      end
    end
  end

  // Array has no reset; gate on rst_i so nothing is written while held in reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_complete && w_wr && !w_err) begin
      r_mem[w_row] <= w_data;
    end
  end

  assign mem_data_o = r_rdata;
  assign mem_ack_o  = r_ack;
  assign busy_o     = r_busy;
  assign err_o      = r_err;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: latency, abort, out-of-range,
// reset mid-request and back-to-back reads, at LATENCY=10 and LATENCY=1.
module tb_line_memory_responder;

  localparam int LAT = 10;
  localparam logic [255:0] P1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] P2 = {8{32'h1111_2222}};
  localparam logic [255:0] P3 = {8{32'h3333_4444}};
  localparam logic [255:0] P4 = {8{32'h5555_6666}};
  localparam logic [255:0] P5 = {8{32'h7777_8888}};
  localparam logic [255:0] P6 = {8{32'h9999_AAAA}};
  localparam logic [255:0] P7 = {8{32'hBBBB_CCCC}};
  localparam logic [255:0] P8 = {8{32'h0123_4567}};
  localparam logic [255:0] P9 = {8{32'h89AB_CDEF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         en, wr, ack, busy, err;
  logic [31:0]  addr;
  logic [255:0] wdata, rdata;
  logic         en1, wr1, ack1, busy1, err1;
  logic [31:0]  addr1;
  logic [255:0] wdata1, rdata1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always @(posedge clk) cyc++;

  line_memory_responder #(.LATENCY(LAT), .DEPTH(512), .LINE_W(256)) dut (
    .clk_i(clk), .rst_i(rst_n), .mem_enable_i(en), .mem_write_i(wr),
    .mem_addr_i(addr), .mem_data_i(wdata), .mem_data_o(rdata),
    .mem_ack_o(ack), .busy_o(busy), .err_o(err)
  );

  line_memory_responder #(.LATENCY(1), .DEPTH(512), .LINE_W(256)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .mem_enable_i(en1), .mem_write_i(wr1),
    .mem_addr_i(addr1), .mem_data_i(wdata1), .mem_data_o(rdata1),
    .mem_ack_o(ack1), .busy_o(busy1), .err_o(err1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full request on the LATENCY=10 unit; enable held through the ack edge,
  // and request fields scrambled right after acceptance.
  task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d,
                     output logic [255:0] rd, output logic er, output int acc);
    int n_busy, n_ack, lat;
    rd = '0; er = 1'b0; n_ack = 0; lat = 0;
    en = 1'b1; wr = w; addr = a; wdata = d;
    tick;
    acc = cyc;
    n_busy = busy ? 1 : 0;
    wr = ~w; addr = 32'hFFFF_FFE0; wdata = ~d;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick;
      if (busy) n_busy++;
      if (ack) begin
        n_ack++;
        lat = k;
        rd = rdata;
        er = err;
      end
    end
    en = 1'b0;
    chk("latency", lat, LAT);
    chk("ack_count", n_ack, 1);
    chk("busy_cycles", n_busy, LAT + 1);
  endtask

  logic [255:0] rd;
  logic         er;
  int           a0, a1, nack;

  initial begin
    rst_n = 1'b0;
    en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    en1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    req(1'b1, 32'h0000_0000, P4, rd, er, a0);
    req(1'b1, 32'h0000_0040, P1, rd, er, a0);
    chk("t1_werr", er, 0);
    chk("t1_write_keeps_rdata", rdata, 0);
    req(1'b0, 32'h0000_005C, P6, rd, er, a0);
    chk("t1_rd", rd, P1);
    chk("t1_rerr", er, 0);

    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h20; wdata1 = P1;
    tick;
    chk("l1_wack", ack1, 1);
    chk("l1_wbusy", busy1, 1);
    addr1 = 32'hFFFF_FFE0; wdata1 = ~P1;
    tick;
    chk("l1_no_reaccept_ack", ack1, 0);
    chk("l1_no_reaccept_busy", busy1, 0);
    wr1 = 1'b0; addr1 = 32'h20;
    tick;
    chk("l1_rack", ack1, 1);
    chk("l1_rd", rdata1, P1);
    chk("l1_rerr", err1, 0);
    tick;
    chk("l1_ack_drop", ack1, 0);
    en1 = 1'b0;

    req(1'b1, 32'h0000_0080, P2, rd, er, a0);
    en = 1'b1; wr = 1'b1; addr = 32'h80; wdata = P3;
    tick;
    chk("t3_busy", busy, 1);
    nack = 0;
    repeat (5) begin tick; if (ack) nack++; end
    en = 1'b0;
    repeat (4) begin tick; if (ack) nack++; end
    chk("t3_abort_noack", nack, 0);
    chk("t3_abort_busy", busy, 0);
    req(1'b0, 32'h0000_0080, 0, rd, er, a0);
    chk("t3_rd_prior", rd, P2);

    req(1'b1, 32'h0000_4000, P3, rd, er, a0);
    chk("t4_werr", er, 1);
    req(1'b0, 32'h0000_4000, 0, rd, er, a0);
    chk("t4_rerr", er, 1);
    chk("t4_rd_zero", rd, 0);
    req(1'b0, 32'h0000_0000, 0, rd, er, a0);
    chk("t4_line0", rd, P4);
    chk("t4_line0_err", er, 0);

    req(1'b1, 32'h0000_0100, P5, rd, er, a0);
    en = 1'b1; wr = 1'b1; addr = 32'h100; wdata = P6;
    tick;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    chk("t5_ack", ack, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rdata", rdata, 0);
    en = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    req(1'b0, 32'h0000_0100, 0, rd, er, a0);
    chk("t5_rd_old", rd, P5);

    en = 1'b1; wr = 1'b1; addr = 32'h120; wdata = P7;
    tick;
    repeat (LAT) tick;
    chk("t5b_ack_before_rst", ack, 1);
    rst_n = 1'b0;
    #1;
    chk("t5b_ack_drop", ack, 0);
    en = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    req(1'b0, 32'h0000_0120, 0, rd, er, a0);
    chk("t5b_write_kept", rd, P7);

    req(1'b1, 32'h0000_0000, P8, rd, er, a0);
    req(1'b1, 32'h0000_0020, P9, rd, er, a0);
    req(1'b0, 32'h0000_0000, 0, rd, er, a0);
    chk("t6_rd0", rd, P8);
    chk("t6_hold0", rdata, P8);
    req(1'b0, 32'h0000_0020, 0, rd, er, a1);
    chk("t6_rd1", rd, P9);
    chk("t6_accept_gap", a1 - a0, 12);
    repeat (3) tick;
    chk("t6_hold1", rdata, P9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
